lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit directly downstream of the ALU. It consumes ALUResult as the effective address, plus rs2 data and funct3 from the decoder. It runs a handshaked request to the data-memory bus and stalls the core until the access completes. It returns sign- or zero-extended load data to writeback and flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT, 16, number of REQ-state cycles without bus_ack before the access is aborted with BusError; must be at least 1.
ADDR_W, 32, width of ALUResult and bus_addr.

Ports:
clk  input  1  core clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
ALUResult  input  ADDR_W  effective byte address from the ALU
WriteData  input  32  store data (rs2)
Funct3  input  3  RISC-V load/store width/sign field
MemRead  input  1  load request for the current instruction
MemWrite  input  1  store request for the current instruction; wins over MemRead if both are high
Stall  output  1  combinational; the core holds PC and the instruction while high
ReadData  output  32  extended load result, registered
AccessFault  output  1  one-cycle pulse on a misaligned address or illegal Funct3
BusError  output  1  high during the DONE cycle of a timed-out access
bus_req  output  1  request to data memory
bus_we  output  1  1 = write
bus_addr  output  ADDR_W  word-aligned address ({ALUResult[ADDR_W-1:2],2'b00})
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  one-cycle completion strobe from memory
bus_rdata  input  32  read word, valid when bus_ack is high

Behaviour:
- Reset values: state IDLE; ReadData = 0; bus_req, bus_we, bus_be, bus_addr, bus_wdata = 0; AccessFault = 0; BusError = 0; timeout counter = 0.
- States are IDLE, REQ and DONE.
- IDLE, request (MemRead or MemWrite) is legal:
  - Register the address, we, be, wdata, Funct3 and byte offset.
  - Move to REQ.
  - Stall = 1 this cycle.
- IDLE, request is illegal:
  - No bus activity; the state stays IDLE; Stall = 0.
  - AccessFault = 1 on the next cycle for exactly one cycle.
  - Illegal means: half-word access with addr[0] = 1; word access with addr[1:0] != 0; load Funct3 of 011, 110 or 111; store Funct3 of 011 through 111.
- REQ:
  - bus_req = 1. Address, we, be and wdata stay stable until bus_ack.
  - Stall = 1.
  - On bus_ack: capture load data into ReadData (loads only) and move to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT, move to DONE with the BusError flag set and ReadData = 0 for loads.
- DONE:
  - bus_req = 0 and Stall = 0, so the core retires the instruction at this edge.
  - BusError is shown if flagged.
  - Always move to IDLE. The counter clears.
- Minimum latency is 3 cycles (issue, REQ with same-cycle ack, DONE). Stall is high for the first 2.
- bus_ack is ignored outside REQ.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{WriteData[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{WriteData[15:0]}}.
  - SW: be = 1111; wdata = WriteData.
- Load extraction:
  - Select the byte or half-word from bus_rdata by the registered offset.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - For loads, bus_be reflects the accessed lanes.
- ReadData holds its value until the next successful or timed-out load. Stores never modify it.
- Reset mid-access (REQ or DONE): IDLE on the next edge; bus_req drops; any later ack is ignored; ReadData = 0.
- Simultaneous MemRead and MemWrite: handled as a store only.

Decomposition:
- Package lsu_pkg holds:
  - Funct3 constants: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - The state enum lsu_state_t {IDLE, REQ, DONE}.
  - A width helper that returns 0/1/2 from Funct3[1:0].
- One combinational sub-module, lsu_align, handles store lane steering (be, wdata) and load extraction/extension. It keeps the FSM file free of datapath muxing.

Test Plan:
- SW at ALUResult=0x100, WriteData=0xDEADBEEF, ack on the first REQ cycle:
  - bus_addr=0x100, be=1111, wdata=0xDEADBEEF.
  - Stall high for exactly 2 cycles; ReadData unchanged.
- LB at 0x203 with bus_rdata=0x80FF_1234 → ReadData=0xFFFFFF80. Repeat as LBU → 0x00000080.
- LH at 0x202 with rdata=0x8001_0000 → ReadData=0xFFFF8001. SH at 0x202 with WriteData=0x0000ABCD → be=1100, wdata=0xABCDABCD.
- LW at 0x101 → AccessFault pulses 1 cycle, bus_req never rises, Stall stays 0. The same applies to Funct3=011 with MemRead.
- LW with no ack (TIMEOUT=16):
  - bus_req high for 16 cycles.
  - DONE cycle has BusError=1, Stall=0, ReadData=0.
  - Back in IDLE next cycle.
- Reset asserted in the 3rd REQ cycle, then a late ack → IDLE, bus_req=0, ReadData=0; the late ack causes no state change.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: Funct3 codes, FSM states and
// helpers that classify an access by width and legality.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Access width code: 0 = byte, 1 = half-word, 2 = word, 3 = unsupported.
  function automatic logic [1:0] f3_width(input logic [2:0] f3);
    logic [1:0] w;
    case (f3[1:0])
      2'b00:   w = 2'd0;
      2'b01:   w = 2'd1;
      2'b10:   w = 2'd2;
      default: w = 2'd3;
    endcase
    return w;
  endfunction

  // Legal when the Funct3 code exists for the direction and the byte
  // offset is naturally aligned for the access width.
  function automatic logic access_legal(input logic [2:0] f3, input logic is_store,
                                        input logic [1:0] off);
    logic f3_ok;
    logic align_ok;
    if (is_store) begin
      f3_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      f3_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    case (f3_width(f3))
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = (off[0] == 1'b0);
      2'd2:    align_ok = (off == 2'b00);
      default: align_ok = 1'b0;
    endcase
    return f3_ok && align_ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// Byte-lane datapath: steers store data onto the bus lanes and extracts /
// extends load data from the returned word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_offset,
  input  logic        i_st_we,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_offset,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_rep;
  logic [31:0] w_shift;

  // Lane enables and replicated store data for the access width.
  always_comb begin
    o_be  = 4'b0000;
    w_rep = 32'h0000_0000;
    case (f3_width(i_st_funct3))
      2'd0: begin
        o_be  = 4'b0001 << i_st_offset;
        w_rep = {4{i_st_data[7:0]}};
      end
      2'd1: begin
        o_be  = i_st_offset[1] ? 4'b1100 : 4'b0011;
        w_rep = {2{i_st_data[15:0]}};
      end
      2'd2: begin
        o_be  = 4'b1111;
        w_rep = i_st_data;
      end
      default: begin
        o_be  = 4'b0000;
        w_rep = 32'h0000_0000;
      end
    endcase
    o_wdata = i_st_we ? w_rep : 32'h0000_0000;
  end

  // Move the addressed byte/half-word down to bit 0, then extend it.
  always_comb begin
    w_shift = i_rdata >> {i_ld_offset, 3'b000};
    case (i_ld_funct3)
      F3_LB:   o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LW:   o_load_data = i_rdata;
      F3_LBU:  o_load_data = {24'h00_0000, w_shift[7:0]};
      F3_LHU:  o_load_data = {16'h0000, w_shift[15:0]};
      default: o_load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: issues one handshaked data-memory access per load/store,
// stalls the core until it completes, and flags faults and bus timeouts.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       WriteData,
  input  logic [2:0]        Funct3,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              Stall,
  output logic [31:0]       ReadData,
  output logic              AccessFault,
  output logic              BusError,
  lsu_ctrl_if.master        bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  lsu_state_t        r_state;
  lsu_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_req;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic [1:0]        r_offset;
  logic [31:0]       r_read_data;
  logic              r_fault;
  logic              r_bus_err;

  logic              w_req;
  logic              w_legal;
  logic              w_issue;
  logic              w_fault;
  logic              w_timeout;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  // A store wins when MemRead and MemWrite are both set.
  assign w_req     = MemRead | MemWrite;
  assign w_legal   = access_legal(Funct3, MemWrite, ALUResult[1:0]);
  assign w_issue   = (r_state == IDLE) && w_req && w_legal;
  assign w_fault   = (r_state == IDLE) && w_req && !w_legal;
  assign w_timeout = (r_state == REQ) && !bus.bus_ack && ((r_cnt + CNT_W'(1)) == TIMEOUT_C);

  lsu_align u_align (
    .i_st_funct3 (Funct3),
    .i_st_offset (ALUResult[1:0]),
    .i_st_we     (MemWrite),
    .i_st_data   (WriteData),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_offset (r_offset),
    .i_rdata     (bus.bus_rdata),
    .o_load_data (w_load_data)
  );

  // Next state and timeout counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus.bus_ack) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_timeout) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, captured request, load result and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_req       <= 1'b0;
      r_be        <= 4'b0000;
      r_wdata     <= 32'h0000_0000;
      r_funct3    <= 3'b000;
      r_offset    <= 2'b00;
      r_read_data <= 32'h0000_0000;
      r_fault     <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req     <= (w_state_nxt == REQ);
      r_fault   <= w_fault;
      r_bus_err <= w_timeout;
      if (w_issue) begin
        r_addr   <= {ALUResult[ADDR_W-1:2], 2'b00};
        r_we     <= MemWrite;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_funct3 <= Funct3;
        r_offset <= ALUResult[1:0];
      end
      if ((r_state == REQ) && !r_we) begin
        if (bus.bus_ack) begin
          r_read_data <= w_load_data;
        end else if (w_timeout) begin
          r_read_data <= 32'h0000_0000;
        end
      end
    end
  end

  // Stall is combinational so the core freezes in the issue cycle itself.
  assign Stall         = w_issue || (r_state == REQ);
  assign ReadData      = r_read_data;
  assign AccessFault   = r_fault;
  assign BusError      = r_bus_err;
  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver issues directed and random
// loads/stores, a memory model answers the bus, and a monitor compares
// every bus request, completion and fault against queued expectations.
module tb_lsu_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [2:0]  Funct3;
  logic        MemRead;
  logic        MemWrite;
  logic        Stall;
  logic [31:0] ReadData;
  logic        AccessFault;
  logic        BusError;

  lsu_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .Funct3      (Funct3),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Stall       (Stall),
    .ReadData    (ReadData),
    .AccessFault (AccessFault),
    .BusError    (BusError),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          berr;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_rd = 32'h0;
  bit          mon_en   = 1'b1;
  logic [31:0] mem_word = 32'h0;
  int          ack_delay = 0;
  bit          mem_mute = 1'b0;
  bit          force_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h expected no such event", name, act);
  endtask

  // Reference rules: which accesses exist and which are aligned.
  function automatic bit ref_legal(input logic [2:0] f3, input bit st, input logic [31:0] a);
    int size;
    bit ok;
    if (st) ok = (f3 <= 3'd2);
    else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = 1 << (f3 % 4);
    return ok && ((a % size) == 0);
  endfunction

  // Reference load value: pick bytes arithmetically and extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    int unsigned v;
    int          s;
    v = w >> (8 * off);
    case (f3)
      3'd0: begin s = int'(v % 256);   if (s >= 128)   s -= 256;   return 32'(s); end
      3'd1: begin s = int'(v % 65536); if (s >= 32768) s -= 65536; return 32'(s); end
      3'd4: return 32'(v % 256);
      3'd5: return 32'(v % 65536);
      default: return w;
    endcase
  endfunction

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Funct3    = 3'd0;
    ALUResult = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int delay, input bit mute);
    exp_t e;
    bit   legal;
    int   off;
    int   size;
    int   cnt;
    legal   = ref_legal(f3, wr, a);
    off     = int'(a % 4);
    size    = 1 << (f3 % 4);
    e.fault = !legal;
    e.we    = wr;
    e.addr  = a - 32'(off);
    e.be    = 4'(((1 << size) - 1) << off);
    if (size == 1)      e.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
    else if (size == 2) e.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
    else                e.wdata = wd;
    e.berr = legal && mute;
    if (legal && !wr) model_rd = mute ? 32'h0 : ref_load(f3, off, rword);
    e.rd      = model_rd;
    mem_word  = rword;
    ack_delay = delay;
    mem_mute  = mute;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd;
    sbq.push_back(e);
    #1;
    if (!legal) begin
      check("stall_on_illegal", {31'h0, Stall}, 32'h0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("fault_pulse_high", {31'h0, AccessFault}, 32'h1);
      @(negedge clk);
      #1;
      check("fault_pulse_low", {31'h0, AccessFault}, 32'h0);
    end else begin
      cnt = 0;
      while (Stall && cnt < 64) begin
        cnt++;
        @(negedge clk);
        #1;
      end
      check("stall_cycles", 32'(cnt), mute ? 32'(TIMEOUT + 1) : 32'(delay + 2));
      idle_inputs();
    end
  endtask

  // Memory model: acknowledges a request after ack_delay REQ cycles.
  initial begin
    int  wait_cnt;
    bit  given;
    wait_cnt = 0;
    given    = 1'b0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.bus_ack = force_ack;
      if (bus.bus_req && !given && !mem_mute) begin
        if (wait_cnt == ack_delay) begin
          bus.bus_ack   = 1'b1;
          bus.bus_rdata = mem_word;
          given         = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      if (!bus.bus_req) begin
        wait_cnt = 0;
        given    = 1'b0;
      end
    end
  end

  // Monitor: checks request contents, completions and fault pulses.
  initial begin
    bit prev_req;
    bit done_cyc;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      done_cyc = prev_req && !bus.bus_req;
      if (mon_en) begin
        if (AccessFault) begin
          if (sbq.size() == 0 || !sbq[0].fault) fail_event("unexpected_fault", 32'h1);
          else begin
            check("rd_at_fault", ReadData, sbq[0].rd);
            void'(sbq.pop_front());
          end
        end
        if (bus.bus_req) begin
          if (sbq.size() == 0 || sbq[0].fault) fail_event("unexpected_req", bus.bus_addr);
          else begin
            check("bus_we", {31'h0, bus.bus_we}, {31'h0, sbq[0].we});
            check("bus_addr", bus.bus_addr, sbq[0].addr);
            check("bus_be", {28'h0, bus.bus_be}, {28'h0, sbq[0].be});
            if (sbq[0].we) check("bus_wdata", bus.bus_wdata, sbq[0].wdata);
          end
        end
        if (done_cyc) begin
          if (sbq.size() == 0) fail_event("unexpected_done", ReadData);
          else begin
            check("bus_error", {31'h0, BusError}, {31'h0, sbq[0].berr});
            check("read_data", ReadData, sbq[0].rd);
            void'(sbq.pop_front());
          end
        end
        if (BusError && !done_cyc) fail_event("stray_bus_error", 32'h1);
      end
      prev_req = bus.bus_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          mode;
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'h0, Stall}, 32'h0);
    check("rst_readdata", ReadData, 32'h0);
    check("rst_fault", {31'h0, AccessFault}, 32'h0);
    check("rst_buserr", {31'h0, BusError}, 32'h0);
    check("rst_req", {31'h0, bus.bus_req}, 32'h0);
    check("rst_we", {31'h0, bus.bus_we}, 32'h0);
    check("rst_be", {28'h0, bus.bus_be}, 32'h0);
    check("rst_addr", bus.bus_addr, 32'h0);
    check("rst_wdata", bus.bus_wdata, 32'h0);
    reset = 1'b0;

    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check("lb_value", model_rd, 32'hFFFF_FF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 1, 1'b0);
    check("lbu_value", model_rd, 32'h0000_0080);
    do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_0000, 2, 1'b0);
    check("lh_value", model_rd, 32'hFFFF_8001);
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h5555_AAAA, 0, 1'b1);
    do_access(1'b1, 1'b1, 3'b000, 32'h401, 32'h0000_0077, 32'h1111_1111, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_access(mode != 1, mode != 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 15) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, 0, 1'b0);
    check("lw_before_reset", ReadData, 32'h1234_5678);

    // Reset in the third REQ cycle, then a late acknowledge.
    mon_en   = 1'b0;
    mem_mute = 1'b1;
    @(negedge clk);
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h80;
    repeat (3) @(negedge clk);
    #1;
    check("req_before_reset", {31'h0, bus.bus_req}, 32'h1);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    check("mid_rst_req", {31'h0, bus.bus_req}, 32'h0);
    check("mid_rst_stall", {31'h0, Stall}, 32'h0);
    check("mid_rst_readdata", ReadData, 32'h0);
    reset = 1'b0;
    bus.bus_rdata = 32'hFFFF_FFFF;
    force_ack = 1'b1;
    @(negedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    #1;
    check("late_ack_req", {31'h0, bus.bus_req}, 32'h0);
    check("late_ack_stall", {31'h0, Stall}, 32'h0);
    check("late_ack_readdata", ReadData, 32'h0);
    check("late_ack_buserr", {31'h0, BusError}, 32'h0);
    @(negedge clk);
    #1;
    check("late_ack_req2", {31'h0, bus.bus_req}, 32'h0);
    mem_mute = 1'b0;
    model_rd = 32'h0;
    mon_en   = 1'b1;

    do_access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 32'hBEEF_0000, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
